// File: rtl/sig_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sig_dump_pkg
//  Purpose  : Shared constants and state encoding for the signature-dump
//             controller (control-word offsets, start value, FSM states).
//  Revision : 1.0 - initial release
// ============================================================================
package sig_dump_pkg;

    // Byte offsets of the control words relative to the RAM base
    localparam int unsigned SIG_BEGIN_OFS = 8;
    localparam int unsigned SIG_END_OFS   = 12;
    localparam int unsigned SIG_FLAG_OFS  = 16;

    // Value written to the flag word that ends the run
    localparam int unsigned START_VAL     = 1;

    // Dump controller states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_PUSH = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sig_dump_snoop.sv
`default_nettype none
// ============================================================================
//  Module   : sig_dump_snoop
//  Purpose  : Watches core writes to the control words, keeps the latest
//             begin/end signature addresses and flags the start request.
//  Revision : 1.0 - initial release
// ============================================================================
module sig_dump_snoop
    import sig_dump_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] CTRL_BASE = 32'h1000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_begin,
    output logic [ADDR_W-1:0] o_end,
    output logic              o_start
);

    localparam logic [ADDR_W-1:0] c_begin_addr = CTRL_BASE + ADDR_W'(SIG_BEGIN_OFS);
    localparam logic [ADDR_W-1:0] c_end_addr   = CTRL_BASE + ADDR_W'(SIG_END_OFS);
    localparam logic [ADDR_W-1:0] c_flag_addr  = CTRL_BASE + ADDR_W'(SIG_FLAG_OFS);

    logic [ADDR_W-1:0] r_begin;
    logic [ADDR_W-1:0] r_end;
    logic              w_hit_begin;
    logic              w_hit_end;

    assign w_hit_begin = i_we && (i_addr == c_begin_addr);
    assign w_hit_end   = i_we && (i_addr == c_end_addr);

    // Only a write of exactly the start value to the flag word counts
    assign o_start = i_we && (i_addr == c_flag_addr) && (i_data == DATA_W'(START_VAL));

    // Latch the begin/end control words whenever the core writes them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_begin <= '0;
            r_end   <= '0;
        end else begin
            if (w_hit_begin) r_begin <= ADDR_W'(i_data);
            if (w_hit_end)   r_end   <= ADDR_W'(i_data);
        end
    end

    assign o_begin = r_begin;
    assign o_end   = r_end;

endmodule
`default_nettype wire

// File: rtl/sig_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sig_dump_ctrl
//  Purpose  : Lowest-priority bus master that, once the end flag is written,
//             reads the signature region word by word and streams it out on
//             a valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
module sig_dump_ctrl
    import sig_dump_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] CTRL_BASE = 32'h1000_0000,
    parameter int                MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snp_we_i,
    input  logic [ADDR_W-1:0] snp_addr_i,
    input  logic [DATA_W-1:0] snp_data_i,
    output logic              bus_req_o,
    input  logic              bus_gnt_i,
    output logic              bus_re_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              dump_valid_o,
    output logic [DATA_W-1:0] dump_data_o,
    input  logic              dump_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    logic [ADDR_W-1:0] w_begin;
    logic [ADDR_W-1:0] w_end;
    logic              w_start;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_end;
    logic [DATA_W-1:0] r_data;

    logic [ADDR_W-1:0] w_span;
    logic              w_bad;
    logic              w_empty;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_can_start;

    sig_dump_snoop #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CTRL_BASE (CTRL_BASE)
    ) u_snoop (
        .clk     (clk),
        .rst     (rst),
        .i_we    (snp_we_i),
        .i_addr  (snp_addr_i),
        .i_data  (snp_data_i),
        .o_begin (w_begin),
        .o_end   (w_end),
        .o_start (w_start)
    );

    // Configuration check is made up front so the address counter can never wrap
    assign w_span      = w_end - w_begin;
    assign w_bad       = (w_begin[1:0] != 2'b00) || (w_end[1:0] != 2'b00) ||
                         (w_end < w_begin) || ((w_span >> 2) > ADDR_W'(MAX_WORDS));
    assign w_empty     = (w_end == w_begin);
    assign w_addr_inc  = r_addr + ADDR_W'(4);
    assign w_can_start = w_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decision; a held grant lets PUSH jump straight into the next read
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    if (w_bad)        w_next = ST_ERR;
                    else if (w_empty) w_next = ST_DONE;
                    else              w_next = ST_REQ;
                end
            end
            ST_REQ:  if (bus_gnt_i) w_next = ST_RD;
            ST_RD:   w_next = ST_WAIT;
            ST_WAIT: w_next = ST_PUSH;
            ST_PUSH: begin
                if (dump_ready_i) begin
                    if (w_addr_inc == r_end) w_next = ST_DONE;
                    else if (bus_gnt_i)      w_next = ST_RD;
                    else                     w_next = ST_REQ;
                end
            end
            ST_ERR:  w_next = ST_ERR;
            default: w_next = ST_IDLE;
        endcase
    end

    // Work copies of the range, address counter and captured read word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_end  <= '0;
            r_data <= '0;
        end else begin
            if (w_can_start) begin
                r_addr <= w_begin;
                r_end  <= w_end;
            end else if ((r_state == ST_PUSH) && dump_ready_i) begin
                r_addr <= w_addr_inc;
            end
            if (r_state == ST_WAIT) r_data <= bus_rdata_i;
        end
    end

    assign bus_req_o    = (r_state == ST_REQ) || (r_state == ST_RD) ||
                          (r_state == ST_WAIT) || (r_state == ST_PUSH);
    assign busy_o       = bus_req_o;
    assign bus_re_o     = (r_state == ST_RD);
    assign bus_addr_o   = r_addr;
    assign dump_valid_o = (r_state == ST_PUSH);
    assign dump_data_o  = r_data;
    assign done_o       = (r_state == ST_DONE);
    assign err_o        = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_sig_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sig_dump_ctrl
//  Purpose  : Self-checking bench for sig_dump_ctrl with a queue-based
//             expectation model and a per-cycle compare process.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sig_dump_ctrl;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        snp_we_i     = 1'b0;
    logic [31:0] snp_addr_i   = '0;
    logic [31:0] snp_data_i   = '0;
    logic        bus_gnt_i    = 1'b0;
    logic [31:0] bus_rdata_i  = '0;
    logic        dump_ready_i = 1'b0;
    logic        bus_req_o, bus_re_o, dump_valid_o, busy_o, done_o, err_o;
    logic [31:0] bus_addr_o, dump_data_o;

    always #5 clk = ~clk;

    sig_dump_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .snp_we_i     (snp_we_i),
        .snp_addr_i   (snp_addr_i),
        .snp_data_i   (snp_data_i),
        .bus_req_o    (bus_req_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_re_o     (bus_re_o),
        .bus_addr_o   (bus_addr_o),
        .bus_rdata_i  (bus_rdata_i),
        .dump_valid_o (dump_valid_o),
        .dump_data_o  (dump_data_o),
        .dump_ready_i (dump_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Expectation model: pending read addresses and words still to be dumped
    logic [31:0] exp_rd[$];
    logic [31:0] exp_dump[$];
    logic [31:0] dumped[$];
    logic [31:0] rd_log[$];
    logic [31:0] m_begin = '0;
    logic [31:0] m_end   = '0;
    bit          m_started = 1'b0;
    bit          m_err     = 1'b0;
    bit          prev_gnt  = 1'b0;
    bit          busy_m;
    logic [31:0] front;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_00A0 + ((a - 32'h1000_0100) >> 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got 0x%08h, expected no such event", name, act);
    endtask

    task automatic model_reset();
        exp_rd.delete();
        exp_dump.delete();
        m_begin   = '0;
        m_end     = '0;
        m_started = 1'b0;
        m_err     = 1'b0;
    endtask

    // A start is only taken when no dump is pending and no error is latched
    task automatic model_write(input logic [31:0] ofs, input logic [31:0] d);
        if (ofs == 32'd8) m_begin = d;
        else if (ofs == 32'd12) m_end = d;
        else if (ofs == 32'd16 && d == 32'd1 && exp_dump.size() == 0 && !m_err) begin
            m_started = 1'b1;
            if (m_begin[1:0] != 2'b00 || m_end[1:0] != 2'b00 || m_end < m_begin ||
                ((m_end - m_begin) / 4) > 32'd4096)
                m_err = 1'b1;
            else
                for (logic [31:0] a = m_begin; a != m_end; a += 4) begin
                    exp_rd.push_back(a);
                    exp_dump.push_back(mem_word(a));
                end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [31:0] d);
        snp_we_i   = 1'b1;
        snp_addr_i = BASE + ofs;
        snp_data_i = d;
        tick();
        snp_we_i   = 1'b0;
        snp_addr_i = '0;
        snp_data_i = '0;
        model_write(ofs, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (exp_dump.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (exp_dump.size() != 0) fail_now({name, "_timeout"}, 32'(exp_dump.size()));
        tick(2);
    endtask

    task automatic wait_word(input logic [31:0] val, input int budget, input string name);
        int k = 0;
        while (!(dump_valid_o && dump_data_o == val) && k < budget) begin
            tick();
            k++;
        end
        if (!(dump_valid_o && dump_data_o == val)) fail_now({name, "_timeout"}, dump_data_o);
    endtask

    task automatic err_case(input logic [31:0] b, input logic [31:0] e, input string name);
        wr(32'd8, b);
        wr(32'd12, e);
        wr(32'd16, 32'd1);
        tick(2);
        check({name, "_err"}, err_o, 1);
        check({name, "_req"}, bus_req_o, 0);
        do_reset();
    endtask

    // Read responder: data appears exactly one cycle after the read strobe
    logic        re_s;
    logic [31:0] a_s;
    always begin
        @(negedge clk);
        re_s = bus_re_o;
        a_s  = bus_addr_o;
        @(posedge clk);
        #1;
        bus_rdata_i = re_s ? mem_word(a_s) : 32'hDEAD_BEEF;
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            busy_m = (exp_dump.size() != 0);
            check("busy_o", busy_o, busy_m);
            check("bus_req_o", bus_req_o, busy_m);
            check("done_o", done_o, m_started && !busy_m && !m_err);
            check("err_o", err_o, m_err);
            if (bus_re_o) begin
                check("rd_after_gnt", prev_gnt, 1);
                if (exp_rd.size() == 0) fail_now("extra_read", bus_addr_o);
                else begin
                    front = exp_rd.pop_front();
                    check("rd_addr", bus_addr_o, front);
                    rd_log.push_back(bus_addr_o);
                end
            end
            if (dump_valid_o) begin
                if (exp_dump.size() == 0) fail_now("extra_dump", dump_data_o);
                else begin
                    check("dump_data", dump_data_o, exp_dump[0]);
                    if (dump_ready_i) begin
                        void'(exp_dump.pop_front());
                        dumped.push_back(dump_data_o);
                    end
                end
            end
        end
        prev_gnt = bus_gnt_i;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        // Reset state
        check("rst_req", bus_req_o, 0);
        check("rst_re", bus_re_o, 0);
        check("rst_addr", bus_addr_o, 0);
        check("rst_valid", dump_valid_o, 0);
        check("rst_data", dump_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        rst = 1'b0;
        model_reset();
        tick();

        // Start with reset begin/end (both zero): empty dump
        wr(32'd16, 32'd1);
        check("zero_cfg_done", done_o, 1);
        tick(2);

        // Basic 4-word dump with grant and ready held, exact timing
        bus_gnt_i    = 1'b1;
        dump_ready_i = 1'b1;
        wr(32'd8, 32'h1000_0100);
        wr(32'd12, 32'h1000_0110);
        dumped.delete();
        rd_log.delete();
        wr(32'd16, 32'd1);
        tick(12);
        check("t1_last_valid", dump_valid_o, 1);
        check("t1_last_word", dump_data_o, 32'hA3);
        check("t1_done_early", done_o, 0);
        tick();
        check("t1_done", done_o, 1);
        check("t1_req_off", bus_req_o, 0);
        tick();
        check("t1_count", 32'(dumped.size()), 4);
        if (dumped.size() == 4) begin
            check("t1_w0", dumped[0], 32'hA0);
            check("t1_w3", dumped[3], 32'hA3);
            check("t1_rd1", rd_log[1], 32'h1000_0104);
            check("t1_rd3", rd_log[3], 32'h1000_010C);
        end

        // Back-pressure on word 2 for 5 cycles
        dumped.delete();
        rd_log.delete();
        wr(32'd16, 32'd1);
        wait_word(32'hA1, 50, "t2_word1");
        dump_ready_i = 1'b0;
        tick(5);
        check("t2_hold_valid", dump_valid_o, 1);
        check("t2_hold_data", dump_data_o, 32'hA1);
        dump_ready_i = 1'b1;
        wait_idle(100, "t2");
        check("t2_count", 32'(dumped.size()), 4);
        check("t2_reads", 32'(rd_log.size()), 4);

        // Grant drops after the first read for 10 cycles
        dumped.delete();
        rd_log.delete();
        wr(32'd16, 32'd1);
        for (int k = 0; k < 20 && !bus_re_o; k++) tick();
        bus_gnt_i = 1'b0;
        tick(10);
        bus_gnt_i = 1'b1;
        wait_idle(100, "t3");
        check("t3_count", 32'(dumped.size()), 4);
        for (int i = 0; i < dumped.size(); i++)
            check("t3_word", dumped[i], 32'hA0 + 32'(i));

        // Empty range, then misaligned begin -> error
        dumped.delete();
        wr(32'd8, 32'h1000_0200);
        wr(32'd12, 32'h1000_0200);
        wr(32'd16, 32'd1);
        tick();
        check("t4_done", done_o, 1);
        tick(2);
        check("t4_count", 32'(dumped.size()), 0);
        wr(32'd8, 32'h1000_0202);
        wr(32'd16, 32'd1);
        tick(3);
        check("t4_err", err_o, 1);
        check("t4_req", bus_req_o, 0);
        check("t4_done_clr", done_o, 0);
        do_reset();
        check("t4_err_rst", err_o, 0);

        // Further configuration errors, each cleared by reset
        err_case(32'h1000_0100, 32'h1000_0111, "end_mis");
        err_case(32'h1000_0200, 32'h1000_0100, "end_lt");
        err_case(32'h1000_0000, 32'h1000_4004, "len_4097");

        // Maximum accepted length
        dumped.delete();
        wr(32'd8, 32'h1000_0100);
        wr(32'd12, 32'h1000_4100);
        wr(32'd16, 32'd1);
        wait_idle(20000, "max");
        check("max_count", 32'(dumped.size()), 4096);
        check("max_done", done_o, 1);

        // Reset during the PUSH of word 3, then a clean re-run
        wr(32'd12, 32'h1000_0110);
        wr(32'd16, 32'd1);
        wait_word(32'hA2, 50, "t5_word2");
        rst = 1'b1;
        tick();
        check("t5_req", bus_req_o, 0);
        check("t5_valid", dump_valid_o, 0);
        check("t5_re", bus_re_o, 0);
        check("t5_busy", busy_o, 0);
        check("t5_done", done_o, 0);
        check("t5_err", err_o, 0);
        rst = 1'b0;
        model_reset();
        dumped.delete();
        rd_log.delete();
        wr(32'd8, 32'h1000_0100);
        wr(32'd12, 32'h1000_0110);
        wr(32'd16, 32'd1);
        wait_idle(100, "t5");
        check("t5_count", 32'(dumped.size()), 4);
        check("t5_rerun_done", done_o, 1);

        // Flag=2 ignored; flag=1 and a begin rewrite while busy do not disturb the dump
        wr(32'd16, 32'd2);
        tick(3);
        check("t6_flag2_done", done_o, 1);
        check("t6_flag2_busy", busy_o, 0);
        dumped.delete();
        rd_log.delete();
        wr(32'd16, 32'd1);
        tick(2);
        wr(32'd8, 32'h1000_0300);
        wr(32'd16, 32'd1);
        wait_idle(100, "t6");
        check("t6_count", 32'(dumped.size()), 4);
        check("t6_reads", 32'(rd_log.size()), 4);
        if (dumped.size() == 4) check("t6_w3", dumped[3], 32'hA3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sig_dump_ctrl.md
Name: sig_dump_ctrl

Overview:
- Bus-master controller that ends a compliance run and reads out the result signature.
- Snoops core writes to the RAM control words: begin-signature (word 2), end-signature (word 3) and end flag (word 4).
- When the end flag is written with 1, it requests the shared memory bus, reads every word in [begin, end), and streams each word out on a valid/ready port for dump or UART logging.
- Sits beside the core on the SoC bus as an extra, lowest-priority master; the bus arbiter owns grant.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.
- CTRL_BASE, 32'h1000_0000, RAM base address; control words are at CTRL_BASE+8, +0xC and +0x10.
- MAX_WORDS, 4096, largest signature length accepted, in words.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- snp_we_i  in  1  core bus write strobe (snoop only)
- snp_addr_i  in  ADDR_W  core bus write address
- snp_data_i  in  DATA_W  core bus write data
- bus_req_o  out  1  bus request to arbiter
- bus_gnt_i  in  1  bus grant
- bus_re_o  out  1  read strobe, one cycle per word
- bus_addr_o  out  ADDR_W  read address
- bus_rdata_i  in  DATA_W  read data, valid exactly 1 cycle after bus_re_o
- dump_valid_o  out  1  signature word available
- dump_data_o  out  DATA_W  signature word
- dump_ready_i  in  1  consumer accepts word
- busy_o  out  1  dump in progress
- done_o  out  1  dump finished (sticky)
- err_o  out  1  bad configuration (sticky)

Behaviour:
- Reset: all outputs 0; begin_q = end_q = 0; addr counter 0; state IDLE.
- Snoop (any state):
  - snp_we_i && addr == CTRL_BASE+8 latches begin_q.
  - addr == CTRL_BASE+0xC latches end_q.
  - The start event is snp_we_i && addr == CTRL_BASE+0x10 && data == 1.
  - A start event is honoured only in IDLE or DONE, and is ignored in all other states.
  - A latch and a start in the same cycle cannot occur (single write port).
- IDLE: wait for start. On start, clear done_o and validate:
  - begin_q[1:0] != 0, end_q[1:0] != 0, end_q < begin_q, or (end_q-begin_q)>>2 > MAX_WORDS -> ERR.
  - end_q == begin_q -> DONE next cycle, zero words emitted.
  - Otherwise addr = begin_q -> REQ.
- REQ: bus_req_o=1 and busy_o=1. busy_o is 1 in every state from REQ through PUSH.
- bus_req_o stays high from REQ until the DONE entry cycle.
- REQ with bus_gnt_i=1 -> RD. Without grant, remain in REQ.
- RD: bus_re_o=1 and bus_addr_o=addr for exactly one cycle -> WAIT. RD is entered only when bus_gnt_i was 1 in the prior cycle.
- WAIT: capture bus_rdata_i into data_q -> PUSH. The capture happens even if grant has dropped (the read is already in flight).
- PUSH: dump_valid_o=1 and dump_data_o=data_q.
  - Hold stable until dump_ready_i.
  - On handshake: addr += 4. If the new addr == end_q -> DONE, else -> REQ (grant is re-checked before every read).
- Best case is 1 word per 3 cycles (REQ/RD/WAIT/PUSH overlap when the grant is held: PUSH goes directly to RD when bus_gnt_i=1).
- DONE: done_o=1, bus_req_o=0, busy_o=0. A new start re-runs the dump with the current begin_q/end_q.
- ERR: err_o=1, no bus activity; leave only via rst.
- Address arithmetic is ADDR_W-bit unsigned. The length check is done before any read, so the counter never wraps.
- rst mid-dump: abort immediately; bus_req_o and dump_valid_o drop in the cycle after rst is sampled; the partial word is discarded.
- Snoop writes to begin/end during a dump update begin_q/end_q but do not affect the dump in progress. Copies are taken at start into work registers.

Decomposition:
- Shared package holds:
  - control-word offsets (SIG_BEGIN_OFS=8, SIG_END_OFS=12, SIG_FLAG_OFS=16);
  - the start value 1;
  - the state encoding (IDLE, REQ, RD, WAIT, PUSH, DONE, ERR).
- One natural sub-module: sig_dump_snoop (address decode, begin/end latches, start pulse). The FSM, counter and output register stay in the top.

Test Plan:
- Write begin=0x10000100, end=0x10000110, flag=1; memory holds 0xA0..0xA3; grant and ready always 1 -> exactly 4 words 0xA0,0xA1,0xA2,0xA3 with reads at 0x10000100/104/108/10C; then done_o=1, bus_req_o=0.
- Same setup, but dump_ready_i low for 5 cycles on word 2 -> dump_data_o holds 0xA1 with valid high throughout; no extra bus_re_o is issued.
- Grant toggles (drops after the first read for 10 cycles) -> no bus_re_o while gnt=0; all 4 words still correct and in order.
- begin=end=0x10000200, flag=1 -> zero dump_valid_o pulses, done_o=1 within 2 cycles. Then begin=0x10000202 and flag=1 -> err_o=1, no bus_req_o.
- rst asserted during the PUSH of word 3 -> all outputs 0 the next cycle. Re-run after release produces the full 4 words.
- Flag write of 2, and a flag=1 write while busy -> both ignored; the word count is unchanged.
